pipe_reg_chain: RTL and testbench



---
 rtl/pipe_reg_chain.sv | 112 +++++++++++
 tb/tb_pipe_reg_chain.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Elastic multi-stage pipeline register chain with valid/ready handshake, bubble collapsing,
// synchronous flush and a registered occupancy count. Optional stall counter: PIPE_REG_CHAIN_STALL_CNT_EN.
module pipe_reg_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  generate
    if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
      $error("pipe_reg_chain: STAGES must be in 1..16");
    end
  endgenerate

  // Handshake: a beat moves across a boundary in any cycle where valid and ready are both 1
  // at that boundary; valid never waits on ready, ready may depend on downstream ready.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] acc;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] up_v;
  logic [WIDTH-1:0]  d    [STAGES];
  logic [WIDTH-1:0]  up_d [STAGES];
  logic              in_hs;
  logic              out_hs;

  // acc/adv ripple from the output side so an empty stage absorbs a beat even under a stall.
  always_comb begin
    adv = '0;
    acc = '0;
    adv[STAGES-1] = v[STAGES-1] & out_ready;
    acc[STAGES-1] = ~v[STAGES-1] | adv[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = v[i] & acc[i+1];
      acc[i] = ~v[i] | adv[i];
    end
  end

  assign in_ready = acc[0] & ~flush & ~r;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = adv[STAGES-1];

  always_comb begin
    up_v    = '0;
    up_v[0] = in_hs;
    up_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      up_v[i] = adv[i-1];
      up_d[i] = d[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else if (flush) begin
      v         <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (acc[i]) begin
          v[i] <= up_v[i];
          // Bubbles never overwrite data; only real beats load.
          if (up_v[i]) d[i] <= up_d[i];
        end
      end
      occupancy <= occupancy + OCC_W'(in_hs) - OCC_W'(out_hs);
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  // Counts output-side stall cycles; survives flush, saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (r) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Default build carries no stall counter.
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!r) begin
      occ_matches_valid : assert (occupancy == OCC_W'($countones(v)));
      occ_in_range      : assert (occupancy <= OCC_W'(STAGES));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: three instances (STAGES 3/2/4, WIDTH 8) share stimulus; sel picks
// which one is observed. Table-driven cycle vectors plus a queue scoreboard on the data path.
module tb_pipe_reg_chain;

  logic       clk;
  logic       r;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready_s  [3];
  logic       out_valid_s [3];
  logic [7:0] out_data_s  [3];
  logic [1:0] occ_a;
  logic [1:0] occ_b;
  logic [2:0] occ_c;

  logic       in_ready_m;
  logic       out_valid_m;
  logic [7:0] out_data_m;
  logic [2:0] occ_m;
  int         sel;

  int n_vec;
  int n_err;
  logic [7:0] exp_q[$];

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  logic [15:0] stall_s [3];
  logic [15:0] stall_m;
`endif

  pipe_reg_chain #(.WIDTH(8), .STAGES(3)) dut_s3 (
    .clk(clk), .r(r), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s[0]),
    .in_data(in_data), .out_valid(out_valid_s[0]), .out_ready(out_ready),
    .out_data(out_data_s[0]), .occupancy(occ_a)
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    , .stall_cnt(stall_s[0])
`endif
  );

  pipe_reg_chain #(.WIDTH(8), .STAGES(2)) dut_s2 (
    .clk(clk), .r(r), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s[1]),
    .in_data(in_data), .out_valid(out_valid_s[1]), .out_ready(out_ready),
    .out_data(out_data_s[1]), .occupancy(occ_b)
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    , .stall_cnt(stall_s[1])
`endif
  );

  pipe_reg_chain #(.WIDTH(8), .STAGES(4)) dut_s4 (
    .clk(clk), .r(r), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s[2]),
    .in_data(in_data), .out_valid(out_valid_s[2]), .out_ready(out_ready),
    .out_data(out_data_s[2]), .occupancy(occ_c)
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    , .stall_cnt(stall_s[2])
`endif
  );

  always_comb begin
    in_ready_m  = in_ready_s[0];
    out_valid_m = out_valid_s[0];
    out_data_m  = out_data_s[0];
    occ_m       = {1'b0, occ_a};
    case (sel)
      1: begin
        in_ready_m  = in_ready_s[1];
        out_valid_m = out_valid_s[1];
        out_data_m  = out_data_s[1];
        occ_m       = {1'b0, occ_b};
      end
      2: begin
        in_ready_m  = in_ready_s[2];
        out_valid_m = out_valid_s[2];
        out_data_m  = out_data_s[2];
        occ_m       = occ_c;
      end
      default: ;
    endcase
  end

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  always_comb begin
    stall_m = stall_s[0];
    if (sel == 1) stall_m = stall_s[1];
    if (sel == 2) stall_m = stall_s[2];
  end
`endif

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (sel=%0d t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  // scoreboard: push on input handshake, pop/compare on output handshake
  always @(negedge clk) begin
    if (in_valid && in_ready_m) exp_q.push_back(in_data);
    if (out_valid_m && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got 0x%0h expected no beat (sel=%0d t=%0t)", out_data_m, sel, $time);
      end else begin
        chk("out_data", 32'(out_data_m), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic do_reset(input int s, input logic iv);
    r = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = iv; in_data = 8'hC3; sel = s;
    @(negedge clk);
    chk("rst_in_ready_a", 32'(in_ready_m), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_b", 32'(in_ready_m), 32'd0);
    chk("rst_out_valid", 32'(out_valid_m), 32'd0);
    chk("rst_out_data", 32'(out_data_m), 32'd0);
    chk("rst_occupancy", 32'(occ_m), 32'd0);
    @(posedge clk);
    #1 r = 1'b0; in_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_beat(input logic [7:0] dat);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = dat;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready_m) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for beat 0x%0h, required 1 within 50 cycles", dat);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tbl[17];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk);
      #1 in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("row%0d_in_ready", i), 32'(in_ready_m), 32'(tbl[i].e_ir));
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid_m), 32'(tbl[i].e_ov));
      chk($sformatf("row%0d_occupancy", i), 32'(occ_m), 32'(tbl[i].e_occ));
      if (tbl[i].e_ov) chk($sformatf("row%0d_out_data", i), 32'(out_data_m), 32'(tbl[i].e_od));
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] first;
    logic [7:0] dat;
    bit seen;
    n_vec = 0; n_err = 0; sel = 0;
    r = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // stall/collapse on STAGES=3: rows 0..9
    tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1};
    tbl[2]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2};
    tbl[3]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd3};
    tbl[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd3};
    tbl[5]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd3};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd3};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    // streaming on STAGES=3: rows 10..16, three-cycle latency
    tbl[10] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[11] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1};
    tbl[12] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 3'd2};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 3'd3};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd2};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};

    // reset with in_valid held high
    do_reset(0, 1'b1);
    run_rows(0, 9);
    do_reset(0, 1'b0);
    run_rows(10, 16);

    // flush on STAGES=2 with a beat offered in the flush cycle
    do_reset(1, 1'b0);
    send_beat(8'h66);
    send_beat(8'h77);
    @(negedge clk);
    chk("flush_pre_occ", 32'(occ_m), 32'd2);
    @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready_m), 32'd0);
    chk("flush_cycle_out_valid", 32'(out_valid_m), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid_m), 32'd0);
    chk("flush_occ", 32'(occ_m), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_beat", 32'(out_valid_m), 32'd0);
    end
    out_ready = 1'b0;

    // full STAGES=4 chain: stall, then simultaneous in/out for 10 cycles
    do_reset(2, 1'b0);
    first = 8'($urandom_range(0, 255));
    send_beat(first);
    for (int i = 0; i < 3; i++) send_beat(8'($urandom_range(0, 255)));
    @(negedge clk);
    chk("full_occ", 32'(occ_m), 32'd4);
    chk("full_in_ready", 32'(in_ready_m), 32'd0);
    chk("full_out_data", 32'(out_data_m), 32'(first));
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 in_valid = 1'b1; in_data = 8'($urandom_range(0, 255)); out_ready = 1'b1;
      @(negedge clk);
      chk("shift_in_ready", 32'(in_ready_m), 32'd1);
      chk("shift_occ", 32'(occ_m), 32'd4);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("shift_drained", 32'(exp_q.size()), 32'd0);
    chk("shift_end_occ", 32'(occ_m), 32'd0);

    // random traffic on STAGES=3
    do_reset(0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    do_reset(0, 1'b0);
    chk("stall_rst", 32'(stall_m), 32'd0);
    dat = 8'h5A;
    send_beat(dat);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid_m) seen = 1'b1;
    end
    chk("stall_beat_arrived", 32'(seen), 32'd1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("stall_cnt_5", 32'(stall_m), 32'd5);
    @(posedge clk);
    #1 out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("stall_flush_beat_taken", 32'(exp_q.size()), 32'd0);
    chk("stall_after_flush", 32'(stall_m), 32'd5);
    chk("stall_flush_out_valid", 32'(out_valid_m), 32'd0);
    do_reset(0, 1'b0);
    @(negedge clk);
    chk("stall_after_reset", 32'(stall_m), 32'd0);
`else
    dat = 8'h00;
    seen = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
